note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_note_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - square-wave tone generator with manual note select and ROM sequencer
module note_sequencer #(
    parameter int  CLK_HZ     = 50_000_000,
    parameter int  NUM_NOTES  = 8,
    parameter int  NOTE_TICKS = 25_000_000,
    parameter int  GAP_TICKS  = 2_500_000,
    parameter int  SEQ_LEN    = 16,
    localparam int IDX_W      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_NOTES-1:0] sw,
    input  logic                 mode,
    input  logic                 start,
    output logic                 audioNote,
    output logic [3:0]           noteOnes,
    output logic [3:0]           noteTens,
    output logic [3:0]           noteHund,
    output logic [3:0]           noteThou,
    output logic                 busy,
    output logic [IDX_W-1:0]     seq_idx
);

    function automatic logic [31:0] half_of(input int k);
        int f;
        case (k)
            0:       f = 440;
            1:       f = 330;
            2:       f = 246;
            3:       f = 196;
            4:       f = 147;
            5:       f = 110;
            6:       f = 82;
            default: f = 62;
        endcase
        return (CLK_HZ / (2 * f) > 0) ? 32'(CLK_HZ / (2 * f)) : 32'd1;
    endfunction

    localparam logic [7:0][31:0] HALF = {half_of(7), half_of(6), half_of(5), half_of(4),
                                         half_of(3), half_of(2), half_of(1), half_of(0)};

    function automatic logic [15:0] digits_of(input logic [2:0] k);
        logic [15:0] d;
        case (k)
            3'd0:    d = 16'h0758;
            3'd1:    d = 16'h1758;
            3'd2:    d = 16'h2777;
            3'd3:    d = 16'h3777;
            3'd4:    d = 16'h4777;
            3'd5:    d = 16'h0777;
            3'd6:    d = 16'h1769;
            default: d = 16'h2769;
        endcase
        return d;
    endfunction

    // Ascending 0..7 then descending 7..0, folded into the available notes.
    function automatic logic [2:0] rom_note(input logic [IDX_W-1:0] i);
        int j;
        j = int'(i) % 16;
        if (j >= 8) j = 15 - j;
        return 3'(j % NUM_NOTES);
    endfunction

    typedef enum logic [1:0] {IDLE, MANUAL, SEQ_NOTE, SEQ_GAP} state_t;
    typedef enum logic [1:0] {ACT_SILENT, ACT_START, ACT_PLAY} act_t;

    state_t           state, state_n;
    act_t             act;
    logic [2:0]       act_note;
    logic [31:0]      tick_cnt, tick_n, tone_cnt, tone_n;
    logic             audio_n, busy_n;
    logic [15:0]      digits, digits_n;
    logic [IDX_W-1:0] idx_n;
    logic             sel_valid, sel_valid_n;
    logic [2:0]       sel_note, sel_note_n;
    logic             sw_one;
    logic [2:0]       sw_idx;

    assign {noteThou, noteHund, noteTens, noteOnes} = digits;

    always_comb begin
        sw_idx = '0;
        for (int k = 0; k < NUM_NOTES; k++)
            if (sw[k]) sw_idx = 3'(k);
        sw_one = $onehot(sw);
    end

    always_comb begin
        state_n     = state;
        tick_n      = tick_cnt;
        busy_n      = busy;
        idx_n       = seq_idx;
        sel_valid_n = sel_valid;
        sel_note_n  = sel_note;
        act         = ACT_SILENT;
        act_note    = '0;
        unique case (state)
            IDLE: begin
                tick_n      = '0;
                busy_n      = 1'b0;
                idx_n       = '0;
                sel_valid_n = 1'b0;
                if (!mode) begin
                    state_n = MANUAL;
                end else if (start) begin
                    state_n  = SEQ_NOTE;
                    busy_n   = 1'b1;
                    act      = ACT_START;
                    act_note = rom_note('0);
                end
            end
            MANUAL: begin
                if (mode) begin
                    state_n     = IDLE;
                    sel_valid_n = 1'b0;
                end else if (!sw_one) begin
                    sel_valid_n = 1'b0;
                end else begin
                    sel_valid_n = 1'b1;
                    sel_note_n  = sw_idx;
                    act_note    = sw_idx;
                    act         = (sel_valid && sel_note == sw_idx) ? ACT_PLAY : ACT_START;
                end
            end
            SEQ_NOTE, SEQ_GAP: begin
                if (!mode) begin
                    state_n     = MANUAL;
                    tick_n      = '0;
                    busy_n      = 1'b0;
                    idx_n       = '0;
                    sel_valid_n = 1'b0;
                end else if (state == SEQ_NOTE) begin
                    if (tick_cnt == 32'(NOTE_TICKS - 1)) begin
                        state_n = SEQ_GAP;
                        tick_n  = '0;
                    end else begin
                        tick_n   = tick_cnt + 32'd1;
                        act      = ACT_PLAY;
                        act_note = rom_note(seq_idx);
                    end
                end else if (tick_cnt == 32'(GAP_TICKS - 1)) begin
                    tick_n = '0;
                    if (seq_idx == IDX_W'(SEQ_LEN - 1)) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        busy_n  = 1'b0;
                    end else begin
                        state_n  = SEQ_NOTE;
                        idx_n    = IDX_W'(seq_idx + 1'b1);
                        act      = ACT_START;
                        act_note = rom_note(IDX_W'(seq_idx + 1'b1));
                    end
                end else begin
                    tick_n = tick_cnt + 32'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Tone path: a new note always begins from a cleared counter with the wave low.
    always_comb begin
        tone_n   = '0;
        audio_n  = 1'b0;
        digits_n = 16'h7777;
        case (act)
            ACT_START: digits_n = digits_of(act_note);
            ACT_PLAY: begin
                digits_n = digits;
                if (tone_cnt >= HALF[act_note] - 32'd1) begin
                    audio_n = ~audioNote;
                end else begin
                    tone_n  = tone_cnt + 32'd1;
                    audio_n = audioNote;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            tone_cnt  <= '0;
            audioNote <= 1'b0;
            digits    <= 16'h7777;
            busy      <= 1'b0;
            seq_idx   <= '0;
            sel_valid <= 1'b0;
            sel_note  <= '0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            tone_cnt  <= tone_n;
            audioNote <= audio_n;
            digits    <= digits_n;
            busy      <= busy_n;
            seq_idx   <= idx_n;
            sel_valid <= sel_valid_n;
            sel_note  <= sel_note_n;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer
module tb_note_sequencer;

    localparam int CLK_HZ  = 8800;
    localparam int NOTE_T  = 200;
    localparam int GAP_T   = 20;
    localparam int SLOT    = NOTE_T + GAP_T;
    localparam int SEQ_LEN = 16;
    localparam logic [21:0] SILENT = {1'b0, 16'h7777, 1'b0, 4'd0};

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       mode = 1'b0;
    logic       start = 1'b0;
    logic       audioNote, busy;
    logic [3:0] noteOnes, noteTens, noteHund, noteThou, seq_idx;
    logic [21:0] dut_vec;

    int n_cmp = 0;
    int n_bad = 0;
    int cur, since;

    int          freq    [8] = '{440, 330, 246, 196, 147, 110, 82, 62};
    logic [15:0] dig_tab [8] = '{16'h0758, 16'h1758, 16'h2777, 16'h3777,
                                 16'h4777, 16'h0777, 16'h1769, 16'h2769};

    typedef struct {
        logic [7:0]  sw;
        int          half;
        logic [15:0] dig;
    } man_vec_t;
    man_vec_t vt [12];

    note_sequencer #(
        .CLK_HZ(CLK_HZ), .NUM_NOTES(8), .NOTE_TICKS(NOTE_T), .GAP_TICKS(GAP_T), .SEQ_LEN(SEQ_LEN)
    ) dut (
        .CLK(CLK), .RST(RST), .sw(sw), .mode(mode), .start(start),
        .audioNote(audioNote), .noteOnes(noteOnes), .noteTens(noteTens),
        .noteHund(noteHund), .noteThou(noteThou), .busy(busy), .seq_idx(seq_idx)
    );

    always #5 CLK = ~CLK;

    assign dut_vec = {audioNote, noteThou, noteHund, noteTens, noteOnes, busy, seq_idx};

    function automatic logic [21:0] pk(input logic a, input logic [15:0] d, input logic b,
                                       input logic [3:0] i);
        return {a, d, b, i};
    endfunction

    function automatic int half_hz(input int k);
        return CLK_HZ / (2 * freq[k]);
    endfunction

    // Expected outputs t cycles after the start pulse was sampled.
    function automatic logic [21:0] exp_seq(input int t);
        int e, w, n;
        if (t >= SEQ_LEN * SLOT) return SILENT;
        e = t / SLOT;
        w = t % SLOT;
        if (w >= NOTE_T) return pk(1'b0, 16'h7777, 1'b1, 4'(e));
        n = (e < 8) ? e : 15 - e;
        return pk(((w / half_hz(n)) % 2) == 1, dig_tab[n], 1'b1, 4'(e));
    endfunction

    task automatic man_update();
        int nw;
        nw = -1;
        if ($countones(sw) == 1)
            for (int k = 0; k < 8; k++) if (sw[k]) nw = k;
        if (nw != cur) begin
            cur   = nw;
            since = 0;
        end else begin
            since++;
        end
    endtask

    function automatic logic [21:0] exp_man();
        if (cur < 0) return SILENT;
        return pk(((since / half_hz(cur)) % 2) == 1, dig_tab[cur], 1'b0, 4'd0);
    endfunction

    task automatic chk(input string name, input logic [21:0] exp);
        n_cmp++;
        if (dut_vec !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got audio=%b digits=%h busy=%b idx=%0d, required audio=%b digits=%h busy=%b idx=%0d",
                     name, $time, dut_vec[21], dut_vec[20:5], dut_vec[4], dut_vec[3:0],
                     exp[21], exp[20:5], exp[4], exp[3:0]);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic seq_run(input string name, input int t_from, input int t_to, input int dup_at);
        for (int t = t_from; t <= t_to; t++) begin
            chk(name, exp_seq(t));
            start = (t == dup_at);
            if (t < t_to) step();
        end
        start = 1'b0;
    endtask

    initial begin
        vt[0]  = '{8'h01, 10, 16'h0758};
        vt[1]  = '{8'h02, 13, 16'h1758};
        vt[2]  = '{8'h04, 17, 16'h2777};
        vt[3]  = '{8'h08, 22, 16'h3777};
        vt[4]  = '{8'h10, 29, 16'h4777};
        vt[5]  = '{8'h20, 40, 16'h0777};
        vt[6]  = '{8'h40, 53, 16'h1769};
        vt[7]  = '{8'h80, 70, 16'h2769};
        vt[8]  = '{8'h03, 0,  16'h7777};
        vt[9]  = '{8'h00, 0,  16'h7777};
        vt[10] = '{8'h80, 70, 16'h2769};
        vt[11] = '{8'hFF, 0,  16'h7777};

        sw = 8'($urandom); mode = 1'b1; start = 1'b1;
        #1 RST = 1'b1;
        #1 chk("reset_async", SILENT);
        for (int i = 0; i < 3; i++) begin
            sw = 8'($urandom); mode = 1'($urandom); start = 1'($urandom);
            step();
            chk("reset_hold", SILENT);
        end
        start = 1'b0; mode = 1'b0; sw = 8'h00;
        RST = 1'b0;
        step();
        chk("enter_manual", SILENT);

        for (int v = 0; v < 12; v++) begin
            int n;
            logic a;
            sw = vt[v].sw;
            step();
            n = (vt[v].half > 0) ? 2 * vt[v].half + 3 : 4;
            for (int c = 0; c < n; c++) begin
                a = 1'b0;
                if (vt[v].half > 0) a = ((c / vt[v].half) % 2) == 1;
                chk($sformatf("manual_sw%02h", vt[v].sw), pk(a, vt[v].dig, 1'b0, 4'd0));
                if (c < n - 1) step();
            end
        end

        cur = -1; since = 0;
        for (int s = 0; s < 40; s++) begin
            int r, h;
            r = $urandom_range(0, 9);
            if (r < 8)       sw = 8'(1 << r);
            else if (r == 8) sw = 8'h00;
            else             sw = 8'($urandom_range(0, 255));
            h = $urandom_range(1, 60);
            for (int c = 0; c < h; c++) begin
                step();
                man_update();
                chk("manual_rand", exp_man());
            end
        end

        mode = 1'b1; sw = 8'h00;
        step();
        chk("to_idle", SILENT);
        start = 1'b1;
        step();
        start = 1'b0;
        seq_run("sequence", 0, SEQ_LEN * SLOT + 10, 500);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_after_seq", SILENT);
        end

        start = 1'b1;
        step();
        start = 1'b0;
        seq_run("abort_pre", 0, 5 * SLOT + 50, -1);
        mode = 1'b0; sw = 8'h04;
        step();
        chk("abort", SILENT);
        cur = -1; since = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            man_update();
            chk("after_abort", exp_man());
        end

        mode = 1'b1;
        step();
        chk("to_idle2", SILENT);
        start = 1'b1;
        step();
        start = 1'b0;
        seq_run("rst_pre", 0, 2 * SLOT + 205, -1);
        #2 RST = 1'b1;
        #1 chk("rst_gap_async", SILENT);
        step();
        chk("rst_gap_hold", SILENT);
        RST = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_after_rst", SILENT);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        seq_run("restart", 0, SLOT + 30, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
